mem_ram_rd_burst: RTL and testbench

Burst read master for the read port of the dual-port word RAM (mem_ram).
- Accepts a command (byte start address, word count) on a valid/ready handshake.
- Drives RAD one word per cycle and captures RDO after the RAM's 1-cycle registered latency.
- Delivers the words in order on a valid/ready output stream with backpressure.
- Sits between the RAM read port and consumers such as instruction prefetch and DMA-out.

---
 rtl/mem_pkg.sv | 14 +
 rtl/mem_sync_fifo.sv | 66 ++++++
 rtl/mem_ram_rd_burst.sv | 148 ++++++++++++++
 tb/tb_mem_ram_rd_burst.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the mem_* RAM access blocks.
//   state_e    : burst reader FSM states
//   WORD_BYTES : bytes per RAM word; addresses advance by this amount
package mem_pkg;

  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/mem_sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (flushes contents)
//   push       : write push_data this cycle (ignored when full unless popping)
//   pop        : drop the head word this cycle (ignored when empty)
//   head       : current head word, valid whenever empty is low
//   full/empty : occupancy flags
//   count      : number of stored words
module mem_sync_fifo #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [DWIDTH-1:0]      push_data,
  input  logic                   pop,
  output logic [DWIDTH-1:0]      head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  // A pop frees a slot in the same cycle, so push is allowed when full and popping.
  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/mem_ram_rd_burst.sv
// Burst read master for the read port of the dual-port word RAM.
// Ports:
//   CLK, RST                    : clock, synchronous active-high reset
//   CMD_VALID/READY/ADDR/LEN    : burst command (byte address, word count)
//   RAD / RDO                   : RAM read address out, read data in (1-cycle latency)
//   O_VALID/READY/DATA/LAST     : in-order output word stream with backpressure
//   BUSY                        : burst in progress
//   DONE                        : one-cycle pulse after the final word (or a zero-length command)
module mem_ram_rd_burst
  import mem_pkg::*;
#(
  parameter int unsigned AWIDTH     = 8,
  parameter int unsigned DWIDTH     = 32,
  parameter int unsigned LWIDTH     = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic [AWIDTH-1:0] CMD_ADDR,
  input  logic [LWIDTH-1:0] CMD_LEN,
  output logic [AWIDTH-1:0] RAD,
  input  logic [DWIDTH-1:0] RDO,
  output logic              O_VALID,
  input  logic              O_READY,
  output logic [DWIDTH-1:0] O_DATA,
  output logic              O_LAST,
  output logic              BUSY,
  output logic              DONE
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [AWIDTH-1:0] rad_q, rad_d;
  logic [LWIDTH-1:0] remaining_q, remaining_d;
  logic [LWIDTH-1:0] outstanding_q, outstanding_d;
  logic              inflight_q, inflight_d;
  logic              done_q, done_d;

  logic              issue_c, pop_c;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full, fifo_empty;
  logic [DWIDTH-1:0] fifo_head;

  // Credit rule: words buffered plus the word in flight never exceed the FIFO depth.
  assign issue_c = (state_q == RUN) && (remaining_q != '0) && !fifo_full &&
                   ((32'(fifo_count) + 32'(inflight_q)) < FIFO_DEPTH);
  assign pop_c   = !fifo_empty && O_READY;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    rad_d         = rad_q;
    remaining_d   = remaining_q;
    outstanding_d = outstanding_q;
    inflight_d    = issue_c;
    done_d        = 1'b0;

    if (issue_c) begin
      rad_d = addr_q;
    end

    unique case (state_q)
      IDLE: begin
        if (CMD_VALID) begin
          if (CMD_LEN != '0) begin
            addr_d        = CMD_ADDR & ~AWIDTH'(WORD_BYTES - 1);
            remaining_d   = CMD_LEN;
            outstanding_d = CMD_LEN;
            state_d       = RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (issue_c) begin
          addr_d      = addr_q + AWIDTH'(WORD_BYTES);
          remaining_d = remaining_q - LWIDTH'(1);
          if (remaining_q == LWIDTH'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
      end
      default: state_d = IDLE;
    endcase

    // The handshake of the final word ends the burst.
    if (pop_c && (outstanding_q != '0)) begin
      outstanding_d = outstanding_q - LWIDTH'(1);
      if (outstanding_q == LWIDTH'(1)) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      rad_q         <= '0;
      remaining_q   <= '0;
      outstanding_q <= '0;
      inflight_q    <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      rad_q         <= rad_d;
      remaining_q   <= remaining_d;
      outstanding_q <= outstanding_d;
      inflight_q    <= inflight_d;
      done_q        <= done_d;
    end
  end

  // RDO belongs to the address issued last cycle; push only when a read was in flight.
  mem_sync_fifo #(
    .DWIDTH (DWIDTH),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (inflight_q),
    .push_data (RDO),
    .pop       (pop_c),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // RAD shows the issuing address, otherwise holds the last one issued.
  assign RAD       = issue_c ? addr_q : rad_q;
  assign CMD_READY = (state_q == IDLE);
  assign BUSY      = (state_q != IDLE);
  assign DONE      = done_q;
  assign O_VALID   = !fifo_empty;
  assign O_DATA    = fifo_empty ? '0 : fifo_head;
  assign O_LAST    = !fifo_empty && (outstanding_q == LWIDTH'(1));

endmodule

// File: tb/tb_mem_ram_rd_burst.sv
// Self-checking bench for mem_ram_rd_burst with a behavioural RAM read port.
module tb_mem_ram_rd_burst;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_addr;
  logic [7:0]  cmd_len;
  logic [7:0]  rad;
  logic [31:0] rdo;
  logic        o_valid;
  logic        o_ready;
  logic [31:0] o_data;
  logic        o_last;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  logic [31:0] ram [64];

  // Burst observation record filled by run_burst.
  int          first_valid_cyc, done_cyc, done_cnt, timed_out;
  bit          busy_seen, valid_dropped, cmdrdy_at_done;
  logic [31:0] got_data [$];
  bit          got_last [$];
  int          hs_cyc [$];
  logic [7:0]  rad_trace [$];

  mem_ram_rd_burst #(
    .AWIDTH(8), .DWIDTH(32), .LWIDTH(8), .FIFO_DEPTH(4)
  ) dut (
    .CLK(clk), .RST(rst),
    .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_ADDR(cmd_addr), .CMD_LEN(cmd_len),
    .RAD(rad), .RDO(rdo),
    .O_VALID(o_valid), .O_READY(o_ready), .O_DATA(o_data), .O_LAST(o_last),
    .BUSY(busy), .DONE(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM read port: registered, one cycle latency.
  always @(posedge clk) rdo <= ram[rad[7:2]];

  // Reference: k-th word of a burst starting at byte address a, wrapping at the top.
  function automatic logic [31:0] exp_word(input logic [7:0] a, input int k);
    int idx;
    idx = (int'(a >> 2) + k) % 64;
    return 32'h1000_0000 + 32'(idx);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one command and records everything up to two cycles past DONE.
  task automatic run_burst(input logic [7:0] a, input logic [7:0] l, input int stall, input bit rnd);
    int  cyc;
    bit  prev_valid;
    got_data.delete(); got_last.delete(); hs_cyc.delete(); rad_trace.delete();
    first_valid_cyc = -1; done_cyc = -1; done_cnt = 0; timed_out = 0;
    busy_seen = 0; valid_dropped = 0; cmdrdy_at_done = 0; prev_valid = 0;
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = l; o_ready = 1'b0;
    rad_trace.push_back(rad);
    step();
    cmd_valid = 1'b0;
    cyc = 1;
    while (1) begin
      rad_trace.push_back(rad);
      if (busy) busy_seen = 1;
      if (o_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (prev_valid && !o_valid && cyc <= stall) valid_dropped = 1;
      prev_valid = o_valid;
      o_ready = (cyc < stall) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          cmdrdy_at_done = cmd_ready;
        end
      end
      if (o_valid && o_ready) begin
        got_data.push_back(o_data);
        got_last.push_back(o_last);
        hs_cyc.push_back(cyc);
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
      if (cyc > 3000) begin
        timed_out = 1;
        break;
      end
      step();
      cyc++;
    end
    o_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [43:0] obs, expv;
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; o_ready = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    obs  = {cmd_ready, o_valid, o_last, busy, done, rad, o_data, 3'b000};
    expv = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 3'b000};
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL reset_state: got %h want %h", obs, expv);
    end
  endtask

  task automatic test_basic();
    run_burst(8'h10, 8'd4, 0, 0);
    total++;
    if (timed_out != 0 || got_data.size() != 4) begin
      bad++;
      $display("FAIL basic_count: got %0d words (timeout=%0d) want 4", got_data.size(), timed_out);
    end
    for (int k = 0; k < got_data.size() && k < 4; k++) begin
      total++;
      if (got_data[k] !== exp_word(8'h10, k) || got_last[k] !== (k == 3) || hs_cyc[k] != 3 + k) begin
        bad++;
        $display("FAIL basic_word[%0d]: got data=%h last=%0d cyc=%0d want data=%h last=%0d cyc=%0d",
                 k, got_data[k], got_last[k], hs_cyc[k], exp_word(8'h10, k), (k == 3), 3 + k);
      end
    end
    total++;
    if (first_valid_cyc != 3 || done_cyc != 7 || done_cnt != 1 || cmdrdy_at_done !== 1'b1) begin
      bad++;
      $display("FAIL basic_timing: got first_valid=%0d done_cyc=%0d done_cnt=%0d ready=%0d want 3 7 1 1",
               first_valid_cyc, done_cyc, done_cnt, cmdrdy_at_done);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_rad;
    run_burst(8'h00, 8'd16, 20, 0);
    total++;
    if (timed_out != 0 || got_data.size() != 16) begin
      bad++;
      $display("FAIL bp_count: got %0d words (timeout=%0d) want 16", got_data.size(), timed_out);
    end
    for (int k = 0; k < got_data.size() && k < 16; k++) begin
      total++;
      if (got_data[k] !== exp_word(8'h00, k) || got_last[k] !== (k == 15)) begin
        bad++;
        $display("FAIL bp_word[%0d]: got data=%h last=%0d want data=%h last=%0d",
                 k, got_data[k], got_last[k], exp_word(8'h00, k), (k == 15));
      end
    end
    for (int c = 1; c <= 4; c++) begin
      exp_rad = 8'((c - 1) * 4);
      total++;
      if (rad_trace[c] !== exp_rad) begin
        bad++;
        $display("FAIL bp_rad[%0d]: got %h want %h", c, rad_trace[c], exp_rad);
      end
    end
    total++;
    if (rad_trace[19] !== 8'h0C || valid_dropped || first_valid_cyc != 3) begin
      bad++;
      $display("FAIL bp_stall: got rad19=%h dropped=%0d first_valid=%0d want 0c 0 3",
               rad_trace[19], valid_dropped, first_valid_cyc);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_rad [4];
    exp_rad[0] = 8'hF8; exp_rad[1] = 8'hFC; exp_rad[2] = 8'h00; exp_rad[3] = 8'h04;
    run_burst(8'hF8, 8'd4, 0, 0);
    total++;
    if (timed_out != 0 || got_data.size() != 4 || done_cnt != 1) begin
      bad++;
      $display("FAIL wrap_count: got %0d words done_cnt=%0d want 4 1", got_data.size(), done_cnt);
    end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (k >= got_data.size() || got_data[k] !== exp_word(8'hF8, k) || rad_trace[k + 1] !== exp_rad[k]) begin
        bad++;
        $display("FAIL wrap_word[%0d]: got data=%h rad=%h want data=%h rad=%h", k,
                 (k < got_data.size()) ? got_data[k] : 32'hx, rad_trace[k + 1], exp_word(8'hF8, k), exp_rad[k]);
      end
    end
  endtask

  task automatic test_zero_len();
    run_burst(8'h40, 8'd0, 0, 1);
    total++;
    if (got_data.size() != 0 || first_valid_cyc != -1 || busy_seen) begin
      bad++;
      $display("FAIL zero_len_output: got words=%0d first_valid=%0d busy=%0d want 0 -1 0",
               got_data.size(), first_valid_cyc, busy_seen);
    end
    total++;
    if (done_cyc != 1 || done_cnt != 1) begin
      bad++;
      $display("FAIL zero_len_done: got done_cyc=%0d done_cnt=%0d want 1 1", done_cyc, done_cnt);
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [7:0] a;
    int hs, k;
    bit spurious;
    a = 8'($urandom_range(0, 255));
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = 8'd8; o_ready = 1'b1;
    step();
    cmd_valid = 1'b0;
    hs = 0; k = 0;
    while (hs < 2 && k < 50) begin
      if (o_valid) begin
        total++;
        if (o_data !== exp_word(a, hs)) begin
          bad++;
          $display("FAIL rstmid_word[%0d]: got %h want %h", hs, o_data, exp_word(a, hs));
        end
        hs++;
      end
      step();
      k++;
    end
    total++;
    if (hs < 2) begin
      bad++;
      $display("FAIL rstmid_timeout: got %0d handshakes want 2", hs);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if ({o_valid, busy, cmd_ready, done} !== 4'b0010) begin
      bad++;
      $display("FAIL rstmid_state: got valid/busy/ready/done=%b want 0010", {o_valid, busy, cmd_ready, done});
    end
    o_ready = 1'b0;
    spurious = 0;
    for (int c = 0; c < 4; c++) begin
      if (done || o_valid || busy) spurious = 1;
      step();
    end
    total++;
    if (spurious) begin
      bad++;
      $display("FAIL rstmid_quiet: got activity after reset want none");
    end
    run_burst(8'h20, 8'd2, 0, 0);
    total++;
    if (got_data.size() != 2 || got_data[0] !== 32'h1000_0008 || got_data[1] !== 32'h1000_0009 || done_cnt != 1) begin
      bad++;
      $display("FAIL rstmid_next: got %0d words first=%h done_cnt=%0d want 2 10000008/09 1",
               got_data.size(), (got_data.size() > 0) ? got_data[0] : 32'hx, done_cnt);
    end
  endtask

  task automatic test_cmd_during_burst();
    logic [7:0] a2;
    logic [31:0] q [$];
    int acc, dn, done1, done2;
    bit fin;
    a2 = 8'($urandom_range(0, 255));
    acc = -1; dn = 0; done1 = -1; done2 = -1; fin = 0;
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL busy_cmd_idle_ready: got %0d want 1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_addr = 8'h13; cmd_len = 8'd2; o_ready = 1'b1;
    step();
    cmd_addr = a2; cmd_len = 8'd3;
    for (int c = 1; c < 100 && !fin; c++) begin
      if (o_valid) q.push_back(o_data);
      if (done) begin
        dn++;
        if (dn == 1) done1 = c;
        else begin
          done2 = c;
          fin = 1;
        end
      end
      if (cmd_ready && acc < 0) acc = c;
      step();
      if (acc >= 0) cmd_valid = 1'b0;
    end
    cmd_valid = 1'b0; o_ready = 1'b0;
    total++;
    if (done1 != 5 || acc != 5 || done2 != 11) begin
      bad++;
      $display("FAIL busy_cmd_timing: got done1=%0d accept=%0d done2=%0d want 5 5 11", done1, acc, done2);
    end
    total++;
    if (q.size() != 5) begin
      bad++;
      $display("FAIL busy_cmd_count: got %0d words want 5", q.size());
    end
    for (int k = 0; k < q.size() && k < 5; k++) begin
      total++;
      if (q[k] !== ((k < 2) ? exp_word(8'h13, k) : exp_word(a2, k - 2))) begin
        bad++;
        $display("FAIL busy_cmd_word[%0d]: got %h want %h", k, q[k],
                 (k < 2) ? exp_word(8'h13, k) : exp_word(a2, k - 2));
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] a, l;
    int n_bad_words;
    for (int i = 0; i < 6; i++) begin
      a = 8'($urandom_range(0, 255));
      l = (i == 5) ? 8'd255 : 8'($urandom_range(1, 20));
      run_burst(a, l, 0, 1);
      total++;
      if (timed_out != 0 || got_data.size() != int'(l)) begin
        bad++;
        $display("FAIL rand%0d_count: got %0d words (timeout=%0d) want %0d", i, got_data.size(), timed_out, l);
      end
      n_bad_words = 0;
      for (int k = 0; k < got_data.size(); k++) begin
        if (got_data[k] !== exp_word(a, k) || got_last[k] !== (k == int'(l) - 1)) begin
          if (n_bad_words == 0)
            $display("FAIL rand%0d_word[%0d]: got data=%h last=%0d want data=%h last=%0d",
                     i, k, got_data[k], got_last[k], exp_word(a, k), (k == int'(l) - 1));
          n_bad_words++;
        end
      end
      total++;
      if (n_bad_words != 0) bad++;
      total++;
      if (done_cnt != 1 || hs_cyc.size() == 0 || done_cyc != hs_cyc[hs_cyc.size() - 1] + 1 || cmdrdy_at_done !== 1'b1) begin
        bad++;
        $display("FAIL rand%0d_done: got done_cnt=%0d done_cyc=%0d ready=%0d want 1 after last handshake, ready 1",
                 i, done_cnt, done_cyc, cmdrdy_at_done);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ram[i] = 32'h1000_0000 + 32'(i);
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; o_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_zero_len();
    test_reset_mid_burst();
    test_cmd_during_burst();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
